// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//
// Write-back front end for the register file. Two producers (single-cycle ALU
// results and load results) each feed a one-entry slot. A round-robin arbiter
// picks at most one full slot per cycle, and the chosen result is registered
// onto the register-file write port. A per-register busy scoreboard tracks
// destinations reserved by the issue stage until their write is issued.
//
// Handshake: a transfer happens on a rising edge where xValid && xReady.
// xReady is high when the slot is empty or is being drained this same cycle,
// so each producer can sustain one transfer per cycle.
//
// Ports:
//   clk       rising-edge clock
//   nReset    asynchronous active-low reset
//   aluValid  ALU result valid           aluReady  ALU slot can accept
//   aluDst    ALU destination register   aluData   ALU result
//   memValid  load result valid          memReady  load slot can accept
//   memDst    load destination register  memData   load result
//   resvValid issue stage reserves resvDst
//   resvDst   reserved destination register
//   rfWe      register-file write enable (registered)
//   rfDst     register-file write index (registered)
//   rfData    register-file write data (registered)
//   busy      bit i set = write to register i pending; bit 0 always 0
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                aluValid,
    output logic                aluReady,
    input  logic [4:0]          aluDst,
    input  logic [WordSize-1:0] aluData,
    input  logic                memValid,
    output logic                memReady,
    input  logic [4:0]          memDst,
    input  logic [WordSize-1:0] memData,
    input  logic                resvValid,
    input  logic [4:0]          resvDst,
    output logic                rfWe,
    output logic [4:0]          rfDst,
    output logic [WordSize-1:0] rfData,
    output logic [31:0]         busy
);

    // ALU slot
    logic                r_alu_full;
    logic [4:0]          r_alu_dst;
    logic [WordSize-1:0] r_alu_data;
    // load slot
    logic                r_mem_full;
    logic [4:0]          r_mem_dst;
    logic [WordSize-1:0] r_mem_data;
    // 1 = ALU was granted most recently
    logic                r_last_alu;
    // write port and scoreboard
    logic                r_rf_we;
    logic [4:0]          r_rf_dst;
    logic [WordSize-1:0] r_rf_data;
    logic [31:0]         r_busy;

    logic                w_alu_grant;
    logic                w_mem_grant;
    logic                w_alu_acc;
    logic                w_mem_acc;
    logic [4:0]          w_grant_dst;
    logic [WordSize-1:0] w_grant_data;
    logic [31:0]         w_busy_nxt;

    // On a tie the source that did not win last time is chosen.
    always_comb begin
        w_alu_grant = r_alu_full && (!r_mem_full || !r_last_alu);
        w_mem_grant = r_mem_full && (!r_alu_full ||  r_last_alu);
    end

    assign aluReady  = !r_alu_full || w_alu_grant;
    assign memReady  = !r_mem_full || w_mem_grant;
    assign w_alu_acc = aluValid && aluReady;
    assign w_mem_acc = memValid && memReady;

    always_comb begin
        w_grant_dst  = r_mem_dst;
        w_grant_data = r_mem_data;
        if (w_alu_grant) begin
            w_grant_dst  = r_alu_dst;
            w_grant_data = r_alu_data;
        end
    end

    // Set is applied after clear so a reservation wins a same-edge collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_we) begin
            w_busy_nxt[r_rf_dst] = 1'b0;
        end
        if (resvValid && (resvDst != 5'd0)) begin
            w_busy_nxt[resvDst] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Slots: a transfer to register 0 completes but leaves the slot empty,
    // so the result is dropped. A new entry overrides a same-cycle drain.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_alu_full <= 1'b0;
            r_alu_dst  <= 5'd0;
            r_alu_data <= '0;
            r_mem_full <= 1'b0;
            r_mem_dst  <= 5'd0;
            r_mem_data <= '0;
        end else begin
            if (w_alu_acc && (aluDst != 5'd0)) begin
                r_alu_full <= 1'b1;
                r_alu_dst  <= aluDst;
                r_alu_data <= aluData;
            end else if (w_alu_grant) begin
                r_alu_full <= 1'b0;
            end
            if (w_mem_acc && (memDst != 5'd0)) begin
                r_mem_full <= 1'b1;
                r_mem_dst  <= memDst;
                r_mem_data <= memData;
            end else if (w_mem_grant) begin
                r_mem_full <= 1'b0;
            end
        end
    end

    // Output stage, arbitration pointer and scoreboard.
    // Reset pointer = ALU so the load path wins the first tie.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_last_alu <= 1'b1;
            r_rf_we    <= 1'b0;
            r_rf_dst   <= 5'd0;
            r_rf_data  <= '0;
            r_busy     <= '0;
        end else begin
            r_rf_we <= w_alu_grant || w_mem_grant;
            if (w_alu_grant || w_mem_grant) begin
                r_rf_dst   <= w_grant_dst;
                r_rf_data  <= w_grant_data;
                r_last_alu <= w_alu_grant;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign rfWe   = r_rf_we;
    assign rfDst  = r_rf_dst;
    assign rfData = r_rf_data;
    assign busy   = r_busy;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int W = 32;

    logic         clk;
    logic         nReset;
    logic         aluValid;
    logic         aluReady;
    logic [4:0]   aluDst;
    logic [W-1:0] aluData;
    logic         memValid;
    logic         memReady;
    logic [4:0]   memDst;
    logic [W-1:0] memData;
    logic         resvValid;
    logic [4:0]   resvDst;
    logic         rfWe;
    logic [4:0]   rfDst;
    logic [W-1:0] rfData;
    logic [31:0]  busy;

    int n_total = 0;
    int n_bad   = 0;

    // expected register writes, {dst, data}, in issue order
    logic [W+4:0] exp_q[$];

    regfile_writeback #(.WordSize(W)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .aluValid  (aluValid),
        .aluReady  (aluReady),
        .aluDst    (aluDst),
        .aluData   (aluData),
        .memValid  (memValid),
        .memReady  (memReady),
        .memDst    (memDst),
        .memData   (memData),
        .resvValid (resvValid),
        .resvDst   (resvDst),
        .rfWe      (rfWe),
        .rfDst     (rfDst),
        .rfData    (rfData),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] d, input logic [W-1:0] x);
        aluValid = v;
        aluDst   = d;
        aluData  = x;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] d, input logic [W-1:0] x);
        memValid = v;
        memDst   = d;
        memData  = x;
    endtask

    task automatic drive_resv(input logic v, input logic [4:0] d);
        resvValid = v;
        resvDst   = d;
    endtask

    // scoreboard: every issued write must match the head of exp_q
    always @(negedge clk) begin
        if (nReset === 1'b1 && rfWe !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_we", {59'd0, rfDst}, 64'd0);
            end else begin
                check_eq("wb_write", {27'd0, rfDst, rfData}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [W-1:0] x;
        nReset = 1'b0;
        drive_alu(1'b0, 5'd0, '0);
        drive_mem(1'b0, 5'd0, '0);
        drive_resv(1'b0, 5'd0);
        repeat (2) tick();
        nReset = 1'b1;
        repeat (2) tick();

        // reset asserted mid-cycle takes effect immediately
        #3 nReset = 1'b0;
        #1;
        check_eq("rst_we",     rfWe,     0);
        check_eq("rst_busy",   busy,     0);
        check_eq("rst_aluRdy", aluReady, 1);
        check_eq("rst_memRdy", memReady, 1);
        tick();
        nReset = 1'b1;
        repeat (3) tick();
        check_eq("idle_we", rfWe, 0);

        // single ALU write with reservation
        drive_resv(1'b1, 5'd5);
        tick();
        drive_resv(1'b0, 5'd0);
        check_eq("single_busy_set", busy, 32'h20);
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        check_eq("single_ready", aluReady, 1);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        tick();
        drive_alu(1'b0, 5'd0, '0);
        check_eq("single_lat_we0", rfWe, 0);
        tick();
        check_eq("single_we",   rfWe,   1);
        check_eq("single_dst",  rfDst,  5);
        check_eq("single_data", rfData, 32'hDEADBEEF);
        check_eq("single_busy_hold", busy, 32'h20);
        tick();
        check_eq("single_busy_clr", busy, 0);
        check_eq("single_we_off", rfWe, 0);

        // simultaneous pair, last grant was ALU -> load first
        drive_alu(1'b1, 5'd3, 32'h11);
        drive_mem(1'b1, 5'd4, 32'h22);
        exp_q.push_back({5'd4, 32'h22});
        exp_q.push_back({5'd3, 32'h11});
        tick();
        drive_alu(1'b0, 5'd0, '0);
        drive_mem(1'b0, 5'd0, '0);
        check_eq("pair1_aluRdy_wait", aluReady, 0);
        check_eq("pair1_memRdy",      memReady, 1);
        tick();
        check_eq("pair1_first_dst", rfDst, 4);
        check_eq("pair1_aluRdy_go", aluReady, 1);
        tick();
        check_eq("pair1_second_dst", rfDst, 3);
        tick();

        // a lone load write moves the pointer to load
        drive_mem(1'b1, 5'd9, 32'h99);
        exp_q.push_back({5'd9, 32'h99});
        tick();
        drive_mem(1'b0, 5'd0, '0);
        repeat (2) tick();

        // second pair -> ALU first
        drive_alu(1'b1, 5'd10, 32'hAA);
        drive_mem(1'b1, 5'd11, 32'hBB);
        exp_q.push_back({5'd10, 32'hAA});
        exp_q.push_back({5'd11, 32'hBB});
        tick();
        drive_alu(1'b0, 5'd0, '0);
        drive_mem(1'b0, 5'd0, '0);
        check_eq("pair2_memRdy_wait", memReady, 0);
        check_eq("pair2_aluRdy",      aluReady, 1);
        tick();
        check_eq("pair2_first_dst", rfDst, 10);
        tick();
        check_eq("pair2_second_dst", rfDst, 11);
        repeat (2) tick();

        // back-to-back ALU stream, dst 1..8
        for (int i = 0; i < 8; i++) begin
            x = $urandom();
            drive_alu(1'b1, 5'(i + 1), x);
            exp_q.push_back({5'(i + 1), x});
            check_eq("stream_ready", aluReady, 1);
            tick();
            if (i > 0) check_eq("stream_we", rfWe, 1);
        end
        drive_alu(1'b0, 5'd0, '0);
        tick();
        check_eq("stream_tail_we", rfWe, 1);
        check_eq("stream_tail_dst", rfDst, 8);
        tick();
        check_eq("stream_end_we", rfWe, 0);

        // zero destination: accepted, dropped, reservation ignored
        drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        check_eq("zero_ready", aluReady, 1);
        tick();
        drive_alu(1'b0, 5'd0, '0);
        tick();
        check_eq("zero_we_a", rfWe, 0);
        drive_resv(1'b1, 5'd0);
        tick();
        drive_resv(1'b0, 5'd0);
        check_eq("zero_we_b", rfWe, 0);
        check_eq("zero_resv_busy", busy, 0);

        // set/clear collision on register 7
        drive_resv(1'b1, 5'd7);
        tick();
        drive_resv(1'b0, 5'd0);
        drive_alu(1'b1, 5'd7, 32'h77);
        exp_q.push_back({5'd7, 32'h77});
        tick();
        drive_alu(1'b0, 5'd0, '0);
        tick();
        check_eq("coll_we", rfWe, 1);
        drive_resv(1'b1, 5'd7);
        tick();
        drive_resv(1'b0, 5'd0);
        check_eq("coll_busy", busy, 32'h80);

        // reset with both slots full discards them
        drive_alu(1'b1, 5'd12, 32'hC0C0);
        drive_mem(1'b1, 5'd13, 32'hD0D0);
        drive_resv(1'b1, 5'd12);
        tick();
        drive_alu(1'b0, 5'd0, '0);
        drive_mem(1'b0, 5'd0, '0);
        drive_resv(1'b0, 5'd0);
        check_eq("full_busy",   busy,     32'h1080);
        check_eq("full_aluRdy", aluReady, 0);
        #3 nReset = 1'b0;
        #1;
        check_eq("mid_rst_we",     rfWe,     0);
        check_eq("mid_rst_busy",   busy,     0);
        check_eq("mid_rst_aluRdy", aluReady, 1);
        check_eq("mid_rst_memRdy", memReady, 1);
        tick();
        @(negedge clk);
        nReset = 1'b1;
        repeat (4) tick();
        check_eq("post_rst_we",   rfWe, 0);
        check_eq("post_rst_busy", busy, 0);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
